// File: rtl/pos_cache_reader.sv
// pos_cache_reader: reads a particle count from cache address 0, then streams
// the positions at addresses 1..N through a 2-entry output FIFO with a
// valid/ready handshake.
// Optional feature: define POS_CACHE_READER_COUNT_CLAMP_EN to clamp counts
// above PARTICLE_NUM and raise a sticky out_count_error.
//
// Handshake: a beat transfers on a cycle where out_valid && in_ready. Once
// out_valid is high, it holds with stable out_particle_info/out_particle_id
// until the beat transfers (or a motion update / reset aborts the pass).
module pos_cache_reader #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 8,
   parameter int PARTICLE_NUM = 220
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      motion_update_enable,
   output logic [ADDR_WIDTH-1:0]     out_read_address,
   output logic                      out_rden,
   input  logic [3*DATA_WIDTH-1:0]   in_particle_info,
   output logic [3*DATA_WIDTH-1:0]   out_particle_info,
   output logic [ADDR_WIDTH-1:0]     out_particle_id,
   output logic                      out_valid,
   input  logic                      in_ready,
   output logic                      out_last,
   output logic                      out_busy,
   output logic                      out_done,
   output logic                      out_count_error,
   output logic [2:0]                out_dbg_state
);
   localparam int PW = 3*DATA_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_RD_NUM, S_WAIT_NUM, S_STREAM, S_DRAIN, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] n_q, n_d, addr_q, addr_d, n_eff;
   logic                  pend_q, pend_d;
   logic [ADDR_WIDTH-1:0] pend_id_q, pend_id_d;
   logic [1:0]            cnt_q, cnt_d;
   logic                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         mem_data_q [2];
   logic [ADDR_WIDTH-1:0] mem_id_q [2];
   logic                  abort, issue, head_from_fifo, accept, push, pop;
   logic [PW-1:0]         head_data;
   logic [ADDR_WIDTH-1:0] head_id;
   logic [1:0]            outstanding;

   // A motion update in any active state kills the pass immediately.
   assign abort       = motion_update_enable && (state_q != S_IDLE);
   // Beats buffered plus a read whose data lands this cycle.
   assign outstanding = cnt_q + {1'b0, pend_q};
   assign out_dbg_state = state_q;

`ifdef POS_CACHE_READER_COUNT_CLAMP_EN
   localparam logic [ADDR_WIDTH-1:0] PN = ADDR_WIDTH'(PARTICLE_NUM);
   logic err_q, err_d, over;

   assign over  = in_particle_info[ADDR_WIDTH-1:0] > PN;
   assign n_eff = over ? PN : in_particle_info[ADDR_WIDTH-1:0];
   assign out_count_error = err_q;

   // Sticky flag: set whenever a latched count had to be clamped.
   always_comb begin
      err_d = err_q;
      if (state_q == S_WAIT_NUM && !abort && over) err_d = 1'b1;
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else     err_q <= err_d;
   end
`else
   assign n_eff = in_particle_info[ADDR_WIDTH-1:0];
   assign out_count_error = 1'b0;
`endif

   // Output FIFO with fall-through: returning data is presented directly when
   // the FIFO is empty and only stored when it cannot leave this cycle.
   always_comb begin
      head_from_fifo = (cnt_q != 2'd0);
      out_valid      = head_from_fifo || pend_q;
      head_data      = head_from_fifo ? mem_data_q[rd_ptr_q] : in_particle_info;
      head_id        = head_from_fifo ? mem_id_q[rd_ptr_q] : pend_id_q;
      accept         = out_valid && in_ready;
      push           = pend_q && (head_from_fifo || !in_ready);
      pop            = accept && head_from_fifo;
      cnt_d          = cnt_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      if (push) begin
         cnt_d    = cnt_d + 2'd1;
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         cnt_d    = cnt_d - 2'd1;
         rd_ptr_d = ~rd_ptr_q;
      end
      if (abort) begin
         cnt_d    = 2'd0;
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
      end
      out_particle_info = out_valid ? head_data : '0;
      out_particle_id   = out_valid ? head_id : '0;
      out_last          = out_valid && (head_id == n_q);
   end

   // FSM next state, read issue and status outputs.
   always_comb begin
      state_d          = state_q;
      n_d              = n_q;
      addr_d           = addr_q;
      issue            = 1'b0;
      out_rden         = 1'b0;
      out_read_address = '0;
      out_busy         = (state_q != S_IDLE);
      out_done         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && !motion_update_enable) state_d = S_RD_NUM;
         end
         S_RD_NUM: begin
            out_rden = 1'b1;
            state_d  = S_WAIT_NUM;
         end
         S_WAIT_NUM: begin
            n_d     = n_eff;
            addr_d  = ADDR_WIDTH'(1);
            state_d = (n_eff == '0) ? S_DONE : S_STREAM;
         end
         S_STREAM: begin
            if (outstanding < 2'd2) begin
               issue            = 1'b1;
               out_rden         = 1'b1;
               out_read_address = addr_q;
               addr_d           = addr_q + ADDR_WIDTH'(1);
               if (addr_q == n_q) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // No reads are issued here, so an empty FIFO next cycle means done.
            if (cnt_d == 2'd0) state_d = S_DONE;
         end
         S_DONE: begin
            out_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         state_d          = S_IDLE;
         issue            = 1'b0;
         out_rden         = 1'b0;
         out_read_address = '0;
         out_done         = 1'b0;
      end
      pend_d    = issue;
      pend_id_d = issue ? addr_q : pend_id_q;
   end

   // State, counters, in-flight tracking and FIFO storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         addr_q    <= '0;
         pend_q    <= 1'b0;
         pend_id_q <= '0;
         cnt_q     <= 2'd0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            mem_data_q[i] <= '0;
            mem_id_q[i]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         addr_q    <= addr_d;
         pend_q    <= pend_d;
         pend_id_q <= pend_id_d;
         cnt_q     <= cnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         if (push && !abort) begin
            mem_data_q[wr_ptr_q] <= in_particle_info;
            mem_id_q[wr_ptr_q]   <= pend_id_q;
         end
      end
   end
endmodule

// File: tb/tb_pos_cache_reader.sv
// Directed bench for pos_cache_reader with a behavioural one-cycle-latency
// position cache. Inputs change and outputs are sampled just after negedge.
module tb_pos_cache_reader;
   localparam int AW = 8;
   localparam int PW = 96;

   logic          clk = 1'b0;
   logic          rst, start, mue, in_ready;
   logic [AW-1:0] out_read_address, out_particle_id;
   logic          out_rden, out_valid, out_last, out_busy, out_done, out_count_error;
   logic [PW-1:0] in_particle_info, out_particle_info;
   logic [2:0]    out_dbg_state;

   logic [PW-1:0] cache [256];
   int pass_cnt = 0;
   int total_cnt = 0;

   logic [AW-1:0] obs_id [$];
   logic [PW-1:0] obs_data [$];
   logic          obs_last [$];
   int            obs_cyc [$];
   logic [AW-1:0] exp_q [$];
   int first_valid, done_cyc, stable_err, max_out, post_done, timeout;
   logic post_busy;

   pos_cache_reader dut (
      .clk(clk), .rst(rst), .start(start), .motion_update_enable(mue),
      .out_read_address(out_read_address), .out_rden(out_rden),
      .in_particle_info(in_particle_info), .out_particle_info(out_particle_info),
      .out_particle_id(out_particle_id), .out_valid(out_valid), .in_ready(in_ready),
      .out_last(out_last), .out_busy(out_busy), .out_done(out_done),
      .out_count_error(out_count_error), .out_dbg_state(out_dbg_state)
   );

   // clock / cache model
   always #5 clk = ~clk;
   always @(posedge clk) if (out_rden) in_particle_info <= cache[out_read_address];

   function automatic logic [PW-1:0] exp_data(input int a);
      logic [31:0] v;
      v = 32'(a);
      return {32'h3000_0000 | v, 32'h2000_0000 | v, 32'h1000_0000 | v};
   endfunction

   // index of first observed beat disagreeing with exp_q, or -1
   function automatic int first_bad_beat();
      for (int i = 0; i < obs_id.size(); i++) begin
         if (i >= exp_q.size()) return i;
         if (obs_id[i] !== exp_q[i] || obs_data[i] !== exp_data(int'(exp_q[i])) ||
             obs_last[i] !== (i == exp_q.size() - 1)) return i;
      end
      return -1;
   endfunction

   task automatic fill_exp(input int n);
      exp_q.delete();
      for (int i = 1; i <= n; i++) exp_q.push_back(AW'(i));
   endtask

   // driver: pulse start, run until out_done (bounded), record observations
   task automatic run_pass(input int cnt, input int mode, input int poke_cyc, input int budget);
      int accepted, issued;
      logic prev_valid, prev_acc;
      logic [PW-1:0] prev_data;
      logic [AW-1:0] prev_id;
      obs_id.delete(); obs_data.delete(); obs_last.delete(); obs_cyc.delete();
      first_valid = -1; done_cyc = -1; stable_err = 0; max_out = 0; post_done = 0;
      timeout = 1; accepted = 0; issued = 0; prev_valid = 0; prev_acc = 0;
      prev_data = '0; prev_id = '0;
      cache[0] = PW'(cnt);
      @(negedge clk); mue = 0; rst = 0; start = 1; in_ready = 1;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clk);
         start = (c == poke_cyc);
         in_ready = (mode == 1) ? c[0] : 1'b1;
         #1;
         if (out_valid && first_valid < 0) first_valid = c;
         if (prev_valid && !prev_acc &&
             (!out_valid || out_particle_info !== prev_data || out_particle_id !== prev_id))
            stable_err++;
         if (out_rden && out_read_address != 0) issued++;
         if (issued - accepted > max_out) max_out = issued - accepted;
         if (out_valid && in_ready) begin
            obs_id.push_back(out_particle_id); obs_data.push_back(out_particle_info);
            obs_last.push_back(out_last); obs_cyc.push_back(c); accepted++;
         end
         prev_valid = out_valid; prev_acc = out_valid && in_ready;
         prev_data = out_particle_info; prev_id = out_particle_id;
         if (out_done) begin
            done_cyc = c; timeout = 0;
            break;
         end
      end
      start = 0; in_ready = 1;
      @(negedge clk); #1; post_busy = out_busy;
      if (out_done) post_done++;
      repeat (2) begin @(negedge clk); #1; if (out_done) post_done++; end
   endtask

   task automatic test_reset();
      rst = 1; start = 0; mue = 0; in_ready = 1;
      repeat (2) @(negedge clk);
      #1;
      total_cnt++;
      if ({out_rden, out_read_address, out_valid, out_particle_info, out_particle_id,
           out_last, out_busy, out_done, out_count_error} !== '0)
         $display("FAIL reset_outputs: got rden=%b addr=%0d valid=%b id=%0d busy=%b done=%b err=%b, need all 0",
                  out_rden, out_read_address, out_valid, out_particle_id, out_busy, out_done, out_count_error);
      else pass_cnt++;
      total_cnt++;
      if (out_dbg_state !== 3'd0) $display("FAIL reset_state: got %0d need 0", out_dbg_state);
      else pass_cnt++;
      @(negedge clk); rst = 0;
   endtask

   task automatic test_count3();
      int bad, span;
      run_pass(3, 0, 0, 50);
      fill_exp(3); bad = first_bad_beat();
      span = (obs_cyc.size() == 3) ? obs_cyc[2] - obs_cyc[0] : -1;
      total_cnt++; if (timeout !== 0) $display("FAIL c3_timeout: no out_done within budget"); else pass_cnt++;
      total_cnt++; if (first_valid !== 4) $display("FAIL c3_first_valid: got %0d need 4", first_valid); else pass_cnt++;
      total_cnt++; if (obs_id.size() !== 3) $display("FAIL c3_beats: got %0d need 3", obs_id.size()); else pass_cnt++;
      total_cnt++; if (bad !== -1) $display("FAIL c3_stream: first bad beat %0d need none", bad); else pass_cnt++;
      total_cnt++; if (span !== 2) $display("FAIL c3_back_to_back: span %0d need 2", span); else pass_cnt++;
      total_cnt++; if (done_cyc !== 7) $display("FAIL c3_done_cycle: got %0d need 7", done_cyc); else pass_cnt++;
      total_cnt++; if (post_done !== 0 || post_busy !== 1'b0)
         $display("FAIL c3_after_done: extra done %0d busy %b need 0 0", post_done, post_busy); else pass_cnt++;
   endtask

   task automatic test_count0();
      run_pass(0, 0, 0, 30);
      total_cnt++; if (first_valid !== -1) $display("FAIL c0_valid: valid at %0d need never", first_valid); else pass_cnt++;
      total_cnt++; if (done_cyc !== 3) $display("FAIL c0_done_cycle: got %0d need 3", done_cyc); else pass_cnt++;
   endtask

   task automatic test_stall();
      int bad;
      run_pass(5, 1, 0, 80);
      fill_exp(5); bad = first_bad_beat();
      total_cnt++; if (obs_id.size() !== 5) $display("FAIL stall_beats: got %0d need 5", obs_id.size()); else pass_cnt++;
      total_cnt++; if (bad !== -1) $display("FAIL stall_stream: first bad beat %0d need none", bad); else pass_cnt++;
      total_cnt++; if (stable_err !== 0) $display("FAIL stall_stable: %0d changes while stalled need 0", stable_err); else pass_cnt++;
      total_cnt++; if (max_out > 2) $display("FAIL stall_outstanding: max %0d need <=2", max_out); else pass_cnt++;
      total_cnt++; if (timeout !== 0) $display("FAIL stall_timeout: no out_done within budget"); else pass_cnt++;
   endtask

   task automatic test_abort();
      int beats, saw, bad;
      beats = 0; saw = 0;
      cache[0] = PW'(10);
      @(negedge clk); start = 1; in_ready = 1; mue = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk); start = 0; #1;
         if (out_valid && in_ready) beats++;
         if (beats == 2) break;
      end
      total_cnt++; if (beats !== 2) $display("FAIL abort_setup: got %0d beats need 2", beats); else pass_cnt++;
      @(negedge clk); mue = 1; #1;
      total_cnt++; if (out_rden !== 1'b0) $display("FAIL abort_rden: got %b need 0", out_rden); else pass_cnt++;
      @(negedge clk); #1;
      total_cnt++; if (out_valid !== 1'b0 || out_busy !== 1'b0)
         $display("FAIL abort_drop: valid %b busy %b need 0 0", out_valid, out_busy); else pass_cnt++;
      repeat (3) begin @(negedge clk); #1; if (out_valid || out_done || out_rden || out_busy) saw++; end
      mue = 0;
      repeat (3) begin @(negedge clk); #1; if (out_valid || out_done || out_rden || out_busy) saw++; end
      total_cnt++; if (saw !== 0) $display("FAIL abort_quiet: %0d active cycles need 0", saw); else pass_cnt++;
      run_pass(10, 0, 0, 100);
      fill_exp(10); bad = first_bad_beat();
      total_cnt++; if (obs_id.size() !== 10 || bad !== -1)
         $display("FAIL abort_replay: beats %0d first bad %0d need 10 none", obs_id.size(), bad); else pass_cnt++;
   endtask

   task automatic test_start_ignored();
      int bad;
      run_pass(4, 0, 5, 60);
      fill_exp(4); bad = first_bad_beat();
      total_cnt++; if (obs_id.size() !== 4 || bad !== -1)
         $display("FAIL busy_start_stream: beats %0d first bad %0d need 4 none", obs_id.size(), bad); else pass_cnt++;
      total_cnt++; if (done_cyc !== 8 || post_done !== 0)
         $display("FAIL busy_start_done: cycle %0d extra %0d need 8 0", done_cyc, post_done); else pass_cnt++;
      // start while a motion update is in progress
      @(negedge clk); mue = 1; start = 1;
      @(negedge clk); start = 0;
      bad = 0;
      repeat (2) begin @(negedge clk); #1; if (out_busy || out_rden) bad++; end
      mue = 0;
      repeat (3) begin @(negedge clk); #1; if (out_busy || out_rden) bad++; end
      total_cnt++; if (bad !== 0) $display("FAIL mue_start: %0d busy cycles need 0", bad); else pass_cnt++;
   endtask

   task automatic test_reset_mid_pass();
      int saw;
      saw = 0;
      cache[0] = PW'(10);
      @(negedge clk); start = 1; in_ready = 0;
      repeat (8) begin @(negedge clk); start = 0; end
      rst = 1; #1;
      total_cnt++; if (out_valid !== 1'b0 || out_busy !== 1'b0 || out_done !== 1'b0)
         $display("FAIL rst_mid: valid %b busy %b done %b need 0 0 0", out_valid, out_busy, out_done); else pass_cnt++;
      @(negedge clk); rst = 0; in_ready = 1;
      repeat (5) begin @(negedge clk); #1; if (out_valid || out_done || out_busy) saw++; end
      total_cnt++; if (saw !== 0) $display("FAIL rst_mid_quiet: %0d active cycles need 0", saw); else pass_cnt++;
   endtask

   task automatic test_count_limit();
      int bad, exp_n;
      logic exp_err;
`ifdef POS_CACHE_READER_COUNT_CLAMP_EN
      exp_n = 220; exp_err = 1'b1;
`else
      exp_n = 250; exp_err = 1'b0;
`endif
      run_pass(250, 0, 0, 400);
      fill_exp(exp_n); bad = first_bad_beat();
      total_cnt++; if (obs_id.size() !== exp_n) $display("FAIL limit_beats: got %0d need %0d", obs_id.size(), exp_n); else pass_cnt++;
      total_cnt++; if (bad !== -1) $display("FAIL limit_stream: first bad beat %0d need none", bad); else pass_cnt++;
      total_cnt++; if (out_count_error !== exp_err) $display("FAIL limit_error: got %b need %b", out_count_error, exp_err); else pass_cnt++;
      total_cnt++; if (timeout !== 0) $display("FAIL limit_timeout: no out_done within budget"); else pass_cnt++;
   endtask

   initial begin
      in_particle_info = '0;
      cache[0] = '0;
      for (int i = 1; i < 256; i++) cache[i] = exp_data(i);
      test_reset();
      test_count3();
      test_count0();
      test_stall();
      test_abort();
      test_start_ignored();
      test_reset_mid_pass();
      test_count_limit();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
